mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
Memory-access (ME) stage that sits directly downstream of the EX/ME pipeline register and upstream of the ME/WB register. For plain ALU results it passes the register write-back triple through unchanged in the same cycle. For loads and stores it runs a multi-beat transaction on a byte-wide data-memory port with a req/ack handshake. It holds the pipeline via stall_req while the transaction runs, then presents the assembled, sign- or zero-extended load result for write-back.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 32, memory address width
REG_ADDR_W, 5, register-file address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
me_w_enable  in  1  write-back enable from EX/ME
me_w_addr  in  REG_ADDR_W  destination register from EX/ME
me_w_data  in  DATA_W  ALU result; effective address when me_mem_en=1
me_mem_en  in  1  instruction is a load/store
me_mem_we  in  1  1=store, 0=load
me_mem_size  in  2  0=byte, 1=half, 2=word, 3=illegal
me_mem_unsigned  in  1  zero-extend load (LBU/LHU)
me_store_data  in  DATA_W  store source (rs2 value)
mem_req  out  1  byte-beat request
mem_we  out  1  beat is a write
mem_addr  out  ADDR_W  byte address of current beat
mem_wdata  out  8  write byte
mem_ack  in  1  beat accepted/completed this cycle
mem_rdata  in  8  read byte, valid when mem_ack=1
stall_req  out  1  hold EX/ME and upstream stages
misalign  out  1  one-cycle misaligned/illegal access flag
wb_w_enable  out  1  to ME/WB
wb_w_addr  out  REG_ADDR_W  to ME/WB
wb_w_data  out  DATA_W  to ME/WB

Behaviour:
- States: IDLE, ACCESS, DONE. While rst=0, go to IDLE immediately; beat counter, latched op, and assembly register clear to 0; all outputs are 0.
- IDLE, me_mem_en=0: wb_* = me_* combinationally (zero latency). stall_req=0, mem_req=0.
- IDLE, me_mem_en=1, misaligned or illegal: misaligned means half with addr[0]=1, or word with addr[1:0]!=0; illegal means size=3.
  - misalign=1 for this cycle, wb_w_enable=0, no bus activity, stall_req=0, stay in IDLE.
- IDLE, me_mem_en=1, aligned:
  - stall_req=1 combinationally in the same cycle.
  - Latch address, store data, size, unsigned flag, we, me_w_enable and me_w_addr.
  - Clear beat counter and assembly register; go to ACCESS.
- ACCESS:
  - Beat count: last beat = 0 for byte, 1 for half, 3 for word.
  - mem_req=1 and stall_req=1.
  - mem_addr = latched address + beat. mem_we = latched we.
  - mem_wdata = store data byte[beat] (little-endian, byte 0 = bits 7:0).
  - Address, data and we are held stable until mem_ack. mem_ack with mem_req=0 is ignored.
  - On mem_ack: for a load, write mem_rdata into assembly byte lane [beat].
  - If beat == last, go to DONE; else beat+1 and mem_req stays high, so back-to-back acks complete one beat per cycle.
- DONE (exactly one cycle):
  - mem_req=0 and stall_req=0; the pipeline advances at the end of this cycle.
  - Load: wb_w_enable = latched enable, wb_w_addr = latched address, wb_w_data = extended result.
    - Byte: sign-extend bit 7, or zero-extend if unsigned.
    - Half: sign-extend bit 15, or zero-extend if unsigned.
    - Word: as assembled.
  - Store: wb_w_enable=0, wb_w_addr and wb_w_data = 0.
  - EX/ME inputs during DONE are ignored. The stage always returns to IDLE, so the same instruction never re-triggers.
- Address arithmetic wraps modulo 2^ADDR_W. Aligned accesses never cross a word boundary.
- Reset mid-ACCESS: mem_req and stall_req drop asynchronously. No partial result reaches wb_*. A later mem_ack is ignored.

Test Plan:
- Non-memory op: me_w_enable=1, me_w_addr=5, me_w_data=0x00001234, me_mem_en=0 -> wb_* = (1, 5, 0x00001234) in the same cycle; stall_req=0; mem_req=0.
- LW at 0x100, mem_ack held high, rdata 0x78, 0x56, 0x34, 0x12:
  - mem_addr 0x100..0x103 on consecutive cycles.
  - stall_req high for 5 cycles (trigger + 4 beats).
  - DONE shows wb_w_data=0x12345678.
- LB at 0x203 with rdata 0x80 -> wb_w_data=0xFFFFFF80. LBU with the same data -> 0x00000080. LH at 0x204 with rdata 0x34, 0x92 -> 0xFFFF9234.
- SH at 0x10, store_data 0xAABBCCDD, first ack delayed 3 cycles:
  - mem_we=1; mem_addr=0x10 and mem_wdata=0xDD held for 4 cycles.
  - Then 0x11 / 0xCC.
  - DONE shows wb_w_enable=0.
- LW at 0x102, then SB with size=3 -> misalign=1 for one cycle each; no mem_req; stall_req=0; wb_w_enable=0.
- rst driven low on the second beat of an LW -> mem_req and stall_req go to 0 the same instant. After release: state IDLE, and a non-memory op passes through correctly.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// EX/ME inputs, byte-wide data-memory port and ME/WB outputs of the memory-access stage.
interface mem_access_stage_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  me_w_enable;
    logic [REG_ADDR_W-1:0] me_w_addr;
    logic [DATA_W-1:0]     me_w_data;
    logic                  me_mem_en;
    logic                  me_mem_we;
    logic [1:0]            me_mem_size;
    logic                  me_mem_unsigned;
    logic [DATA_W-1:0]     me_store_data;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_ack;
    logic [7:0]            mem_rdata;

    logic                  stall_req;
    logic                  misalign;

    logic                  wb_w_enable;
    logic [REG_ADDR_W-1:0] wb_w_addr;
    logic [DATA_W-1:0]     wb_w_data;

    modport master (
        input  me_w_enable, me_w_addr, me_w_data, me_mem_en, me_mem_we,
               me_mem_size, me_mem_unsigned, me_store_data, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, stall_req, misalign,
               wb_w_enable, wb_w_addr, wb_w_data
    );

    modport slave (
        output me_w_enable, me_w_addr, me_w_data, me_mem_en, me_mem_we,
               me_mem_size, me_mem_unsigned, me_store_data, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall_req, misalign,
               wb_w_enable, wb_w_addr, wb_w_data
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU pass-through plus multi-beat byte-wide
// load/store engine that stalls the pipeline until the access completes.
module mem_access_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_stage_if.master  bus_io
);
    localparam int unsigned BEAT_W = 2;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [BEAT_W-1:0]     last_beat;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     sdata_q, sdata_d;
    logic [DATA_W-1:0]     asm_q, asm_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  we_q, we_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic                  bad_access;
    logic [DATA_W-1:0]     load_ext;
    logic [4:0]            lane;

    logic                  mem_req_c;
    logic                  mem_we_c;
    logic [ADDR_W-1:0]     mem_addr_c;
    logic [BYTE_W-1:0]     mem_wdata_c;
    logic                  stall_req_c;
    logic                  misalign_c;
    logic                  wb_w_enable_c;
    logic [REG_ADDR_W-1:0] wb_w_addr_c;
    logic [DATA_W-1:0]     wb_w_data_c;

    // Misaligned half/word or the reserved size encoding.
    always_comb begin
        case (bus_io.me_mem_size)
            2'd0:    bad_access = 1'b0;
            2'd1:    bad_access = bus_io.me_w_data[0];
            2'd2:    bad_access = |bus_io.me_w_data[1:0];
            default: bad_access = 1'b1;
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    last_beat = BEAT_W'(0);
            2'd1:    last_beat = BEAT_W'(1);
            default: last_beat = BEAT_W'(3);
        endcase
    end

    always_comb begin
        case (size_q)
            2'd0:    load_ext = uns_q ? DATA_W'(asm_q[7:0])
                                      : DATA_W'($signed(asm_q[7:0]));
            2'd1:    load_ext = uns_q ? DATA_W'(asm_q[15:0])
                                      : DATA_W'($signed(asm_q[15:0]));
            default: load_ext = asm_q;
        endcase
    end

    assign lane = {1'b0, beat_q, 2'b00} << 1;

    // Next-state and output decode; every output forced low while reset is held.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        addr_d        = addr_q;
        sdata_d       = sdata_q;
        asm_d         = asm_q;
        size_d        = size_q;
        uns_d         = uns_q;
        we_d          = we_q;
        wen_d         = wen_q;
        waddr_d       = waddr_q;
        mem_req_c     = 1'b0;
        mem_we_c      = 1'b0;
        mem_addr_c    = '0;
        mem_wdata_c   = '0;
        stall_req_c   = 1'b0;
        misalign_c    = 1'b0;
        wb_w_enable_c = 1'b0;
        wb_w_addr_c   = '0;
        wb_w_data_c   = '0;

        case (state_q)
            IDLE: begin
                if (!bus_io.me_mem_en) begin
                    wb_w_enable_c = bus_io.me_w_enable;
                    wb_w_addr_c   = bus_io.me_w_addr;
                    wb_w_data_c   = bus_io.me_w_data;
                end else if (bad_access) begin
                    misalign_c = 1'b1;
                end else begin
                    stall_req_c = 1'b1;
                    addr_d      = ADDR_W'(bus_io.me_w_data);
                    sdata_d     = bus_io.me_store_data;
                    size_d      = bus_io.me_mem_size;
                    uns_d       = bus_io.me_mem_unsigned;
                    we_d        = bus_io.me_mem_we;
                    wen_d       = bus_io.me_w_enable;
                    waddr_d     = bus_io.me_w_addr;
                    beat_d      = '0;
                    asm_d       = '0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                mem_req_c   = 1'b1;
                stall_req_c = 1'b1;
                mem_we_c    = we_q;
                mem_addr_c  = addr_q + ADDR_W'(beat_q);
                mem_wdata_c = sdata_q[lane +: BYTE_W];
                if (bus_io.mem_ack) begin
                    if (!we_q) begin
                        asm_d[lane +: BYTE_W] = bus_io.mem_rdata;
                    end
                    if (beat_q == last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!we_q) begin
                    wb_w_enable_c = wen_q;
                    wb_w_addr_c   = waddr_q;
                    wb_w_data_c   = load_ext;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            mem_req_c     = 1'b0;
            mem_we_c      = 1'b0;
            mem_addr_c    = '0;
            mem_wdata_c   = '0;
            stall_req_c   = 1'b0;
            misalign_c    = 1'b0;
            wb_w_enable_c = 1'b0;
            wb_w_addr_c   = '0;
            wb_w_data_c   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            asm_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            asm_q   <= asm_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
        end
    end

    assign bus_io.mem_req     = mem_req_c;
    assign bus_io.mem_we      = mem_we_c;
    assign bus_io.mem_addr    = mem_addr_c;
    assign bus_io.mem_wdata   = mem_wdata_c;
    assign bus_io.stall_req   = stall_req_c;
    assign bus_io.misalign    = misalign_c;
    assign bus_io.wb_w_enable = wb_w_enable_c;
    assign bus_io.wb_w_addr   = wb_w_addr_c;
    assign bus_io.wb_w_data   = wb_w_data_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: bench acts as EX/ME source and byte memory.
module tb_mem_access_stage;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } beat_t;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    beat_t beat_sb[$];
    wb_t   wb_sb[$];

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) bus_if ();

    mem_access_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus_if)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] w);
        case (size)
            2'd0:    return uns ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'd1:    return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        bus_if.me_w_enable     = 1'b0;
        bus_if.me_w_addr       = '0;
        bus_if.me_w_data       = '0;
        bus_if.me_mem_en       = 1'b0;
        bus_if.me_mem_we       = 1'b0;
        bus_if.me_mem_size     = '0;
        bus_if.me_mem_unsigned = 1'b0;
        bus_if.me_store_data   = '0;
    endtask

    task automatic nonmem(input logic en, input logic [4:0] wa, input logic [31:0] wd);
        drive_quiet();
        bus_if.me_w_enable = en;
        bus_if.me_w_addr   = wa;
        bus_if.me_w_data   = wd;
        @(negedge clk);
        check_eq("pass_wen", 64'(bus_if.wb_w_enable), 64'(en));
        check_eq("pass_waddr", 64'(bus_if.wb_w_addr), 64'(wa));
        check_eq("pass_wdata", 64'(bus_if.wb_w_data), 64'(wd));
        check_eq("pass_stall", 64'(bus_if.stall_req), 64'd0);
        check_eq("pass_req", 64'(bus_if.mem_req), 64'd0);
        next_cycle();
    endtask

    task automatic check_beat(input string tag, input beat_t e, inout int stalls);
        check_eq({tag, "_req"}, 64'(bus_if.mem_req), 64'd1);
        check_eq({tag, "_addr"}, 64'(bus_if.mem_addr), 64'(e.addr));
        check_eq({tag, "_we"}, 64'(bus_if.mem_we), 64'(e.we));
        check_eq({tag, "_wdata"}, 64'(bus_if.mem_wdata), 64'(e.wdata));
        if (bus_if.stall_req) stalls++;
    endtask

    // One load/store: expected beats and write-back are queued before driving.
    // dlyw holds a 4-bit ack delay per beat, rdw the little-endian read bytes.
    task automatic mem_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] waddr, input logic [15:0] dlyw,
                          input logic [31:0] rdw);
        int    nb;
        int    stalls;
        int    exp_stalls;
        beat_t b;
        wb_t   w;
        wb_t   got;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        exp_stalls = 1;
        for (int i = 0; i < nb; i++) begin
            b.addr  = addr + 32'(i);
            b.we    = we;
            b.wdata = sdata[8*i +: 8];
            beat_sb.push_back(b);
            exp_stalls += int'(dlyw[4*i +: 4]) + 1;
        end
        if (we) begin
            w.en = 1'b0; w.addr = '0; w.data = '0;
        end else begin
            w.en = 1'b1; w.addr = waddr; w.data = model_load(size, uns, rdw);
        end
        wb_sb.push_back(w);

        drive_quiet();
        bus_if.me_w_enable     = 1'b1;
        bus_if.me_w_addr       = waddr;
        bus_if.me_w_data       = addr;
        bus_if.me_mem_en       = 1'b1;
        bus_if.me_mem_we       = we;
        bus_if.me_mem_size     = size;
        bus_if.me_mem_unsigned = uns;
        bus_if.me_store_data   = sdata;
        stalls = 0;
        @(negedge clk);
        check_eq("trig_stall", 64'(bus_if.stall_req), 64'd1);
        check_eq("trig_req", 64'(bus_if.mem_req), 64'd0);
        check_eq("trig_misalign", 64'(bus_if.misalign), 64'd0);
        if (bus_if.stall_req) stalls++;
        next_cycle();
        drive_quiet();

        for (int i = 0; i < nb; i++) begin
            for (int d = 0; d < int'(dlyw[4*i +: 4]); d++) begin
                @(negedge clk);
                if (beat_sb.size() > 0) check_beat("hold", beat_sb[0], stalls);
                next_cycle();
            end
            bus_if.mem_ack   = 1'b1;
            bus_if.mem_rdata = rdw[8*i +: 8];
            @(negedge clk);
            check_eq("beat_sb_depth", 64'(beat_sb.size() > 0), 64'd1);
            if (beat_sb.size() > 0) check_beat("beat", beat_sb.pop_front(), stalls);
            next_cycle();
            bus_if.mem_ack   = 1'b0;
            bus_if.mem_rdata = '0;
        end

        @(negedge clk);
        check_eq("done_stall", 64'(bus_if.stall_req), 64'd0);
        check_eq("done_req", 64'(bus_if.mem_req), 64'd0);
        check_eq("stall_cycles", 64'(stalls), 64'(exp_stalls));
        check_eq("wb_sb_depth", 64'(wb_sb.size() > 0), 64'd1);
        if (wb_sb.size() > 0) begin
            got = wb_sb.pop_front();
            check_eq("done_wen", 64'(bus_if.wb_w_enable), 64'(got.en));
            check_eq("done_waddr", 64'(bus_if.wb_w_addr), 64'(got.addr));
            check_eq("done_wdata", 64'(bus_if.wb_w_data), 64'(got.data));
        end
        next_cycle();
    endtask

    task automatic bad_op(input logic we, input logic [1:0] size, input logic [31:0] addr);
        drive_quiet();
        bus_if.me_w_enable = 1'b1;
        bus_if.me_w_addr   = 5'd7;
        bus_if.me_w_data   = addr;
        bus_if.me_mem_en   = 1'b1;
        bus_if.me_mem_we   = we;
        bus_if.me_mem_size = size;
        @(negedge clk);
        check_eq("mis_flag", 64'(bus_if.misalign), 64'd1);
        check_eq("mis_req", 64'(bus_if.mem_req), 64'd0);
        check_eq("mis_stall", 64'(bus_if.stall_req), 64'd0);
        check_eq("mis_wen", 64'(bus_if.wb_w_enable), 64'd0);
        next_cycle();
        drive_quiet();
        @(negedge clk);
        check_eq("mis_clear", 64'(bus_if.misalign), 64'd0);
        check_eq("mis_idle_req", 64'(bus_if.mem_req), 64'd0);
        next_cycle();
    endtask

    initial begin
        drive_quiet();
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;
        bus_if.me_w_enable = 1'b1;
        bus_if.me_w_addr   = 5'd5;
        bus_if.me_w_data   = 32'h0000_1234;
        #12;
        check_eq("rst_wen", 64'(bus_if.wb_w_enable), 64'd0);
        check_eq("rst_wdata", 64'(bus_if.wb_w_data), 64'd0);
        check_eq("rst_stall", 64'(bus_if.stall_req), 64'd0);
        check_eq("rst_req", 64'(bus_if.mem_req), 64'd0);
        #5 rst_n = 1'b1;
        next_cycle();

        nonmem(1'b1, 5'd5, 32'h0000_1234);
        nonmem(1'b0, 5'd31, 32'hDEAD_BEEF);

        mem_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 16'h0000, 32'h1234_5678);
        mem_op(1'b0, 2'd0, 1'b0, 32'h0000_0203, 32'h0, 5'd8, 16'h0000, 32'h0000_0080);
        mem_op(1'b0, 2'd0, 1'b1, 32'h0000_0203, 32'h0, 5'd9, 16'h0002, 32'h0000_0080);
        mem_op(1'b0, 2'd1, 1'b0, 32'h0000_0204, 32'h0, 5'd10, 16'h0000, 32'h0000_9234);
        mem_op(1'b0, 2'd1, 1'b1, 32'h0000_0206, 32'h0, 5'd11, 16'h0010, 32'h0000_9234);
        mem_op(1'b1, 2'd1, 1'b0, 32'h0000_0010, 32'hAABB_CCDD, 5'd4, 16'h0003, 32'h0);
        mem_op(1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h0102_0304, 5'd12, 16'h0200, 32'h0);
        mem_op(1'b1, 2'd0, 1'b0, 32'h0000_0033, 32'h0000_005A, 5'd13, 16'h0001, 32'h0);
        mem_op(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0, 5'd14, 16'h1010, 32'h8765_4321);
        mem_op(1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'h0, 5'd15, 16'h0000, 32'h0000_007F);

        bad_op(1'b0, 2'd2, 32'h0000_0102);
        bad_op(1'b1, 2'd3, 32'h0000_0040);
        bad_op(1'b0, 2'd1, 32'h0000_0205);
        nonmem(1'b1, 5'd6, 32'h0BAD_F00D);

        // Reset during the second beat of a word load.
        drive_quiet();
        bus_if.me_w_enable = 1'b1;
        bus_if.me_w_addr   = 5'd2;
        bus_if.me_w_data   = 32'h0000_0300;
        bus_if.me_mem_en   = 1'b1;
        bus_if.me_mem_size = 2'd2;
        next_cycle();
        drive_quiet();
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 8'hAA;
        @(negedge clk);
        check_eq("rb_addr0", 64'(bus_if.mem_addr), 64'h300);
        next_cycle();
        bus_if.mem_ack = 1'b0;
        #1;
        check_eq("rb_addr1", 64'(bus_if.mem_addr), 64'h301);
        check_eq("rb_req_before", 64'(bus_if.mem_req), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rb_req", 64'(bus_if.mem_req), 64'd0);
        check_eq("rb_stall", 64'(bus_if.stall_req), 64'd0);
        check_eq("rb_wen", 64'(bus_if.wb_w_enable), 64'd0);
        bus_if.mem_ack   = 1'b1;
        bus_if.mem_rdata = 8'h55;
        next_cycle();
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rb_late_ack_req", 64'(bus_if.mem_req), 64'd0);
        check_eq("rb_late_ack_stall", 64'(bus_if.stall_req), 64'd0);
        next_cycle();
        @(negedge clk);
        check_eq("rb_idle_req", 64'(bus_if.mem_req), 64'd0);
        check_eq("rb_idle_wen", 64'(bus_if.wb_w_enable), 64'd0);
        next_cycle();
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = '0;
        nonmem(1'b1, 5'd21, 32'hCAFE_F00D);

        check_eq("beat_sb_left", 64'(beat_sb.size()), 64'd0);
        check_eq("wb_sb_left", 64'(wb_sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
